// File: rtl/dot_accumulator.sv
// dot_accumulator: sums N_TERMS products and requantizes the result to 8 bits
// (DOT_ACC_ROUND_EN selects half-up rounding instead of truncation).
module dot_accumulator #(
  parameter int N_TERMS = 16,
  parameter int ACC_W   = 24,
  parameter int SHIFT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      in_product,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [ACC_W-1:0] out_sum,
  output logic             ovf_err
);
  localparam int CW = $clog2(N_TERMS);
`ifdef DOT_ACC_ROUND_EN
  localparam logic [ACC_W:0] HALF = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
`endif
  logic [ACC_W-1:0] acc, sum_c, res_sum;
  logic [ACC_W:0]   sum_w, res_r;
  logic [CW-1:0]    cnt;
  logic             pend, accept, done, load_new, xfer;
  assign in_ready = !pend;
  always_comb begin
    sum_w    = {1'b0, acc} + (ACC_W+1)'(in_product);
    sum_c    = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
    accept   = in_valid && in_ready && !clear;
    done     = accept && cnt == CW'(N_TERMS - 1);
    load_new = done && (!out_valid || out_ready);
    xfer     = pend && out_ready && !clear;
    // One requantizer serves both the direct load and the pending transfer
    res_sum  = load_new ? sum_c : acc;
`ifdef DOT_ACC_ROUND_EN
    res_r    = ({1'b0, res_sum} + HALF) >> SHIFT;
`else
    res_r    = {1'b0, res_sum} >> SHIFT;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sum   <= '0;
      ovf_err   <= 1'b0;
    end else begin
      if (in_valid && !in_ready && !clear) ovf_err <= 1'b1;
      if (clear) begin
        acc  <= '0;
        cnt  <= '0;
        pend <= 1'b0;
      end else if (done) begin
        acc  <= load_new ? '0 : sum_c;
        cnt  <= '0;
        pend <= !load_new;
      end else if (accept) begin
        acc <= sum_c;
        cnt <= cnt + 1'b1;
      end else if (xfer) begin
        acc  <= '0;
        cnt  <= '0;
        pend <= 1'b0;
      end
      if (load_new || xfer) begin
        out_valid <= 1'b1;
        out_sum   <= res_sum;
        out_data  <= |res_r[ACC_W:8] ? 8'hff : res_r[7:0];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dot_accumulator.sv
// tb_dot_accumulator: directed checks of dot_accumulator with N_TERMS=4, SHIFT=4.
module tb_dot_accumulator;
  localparam int ACC_W = 24;
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_product = 0;
  logic in_ready, out_valid, ovf_err;
  logic [7:0] out_data;
  logic [ACC_W-1:0] out_sum;
  int n_chk = 0, n_fail = 0;
`ifdef DOT_ACC_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  dot_accumulator #(.N_TERMS(4), .ACC_W(ACC_W), .SHIFT(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_product(in_product),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sum(out_sum), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] p);
    in_valid = 1;
    in_product = p;
    tick();
    in_valid = 0;
  endtask
  task automatic group(input logic [15:0] p);
    for (int i = 0; i < 4; i++) push(p);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;
    out_ready = 1;
    tick();
    push(16); push(32); push(48);
    chk("g1_not_yet", out_valid, 0);
    push(64);
    chk("g1_valid", out_valid, 1);
    chk("g1_sum", out_sum, 160);
    chk("g1_data", out_data, 10);
    tick();
    chk("g1_pulse", out_valid, 0);
    chk("g1_sum_kept", out_sum, 160);
    push(8); push(0); push(0); push(0);
    chk("g2_sum", out_sum, 8);
    chk("g2_data_rnd", out_data, RND);
    group(16'hffff);
    chk("sat_sum", out_sum, 262140);
    chk("sat_data", out_data, 255);
    tick();
    out_ready = 0;
    group(1);
    chk("bp_g1_valid", out_valid, 1);
    chk("bp_g1_sum", out_sum, 4);
    chk("bp_in_ready_hi", in_ready, 1);
    group(2);
    chk("bp_in_ready_lo", in_ready, 0);
    chk("bp_hold_sum", out_sum, 4);
    chk("bp_ovf_pre", ovf_err, 0);
    push(5);
    chk("bp_ovf_set", ovf_err, 1);
    chk("bp_sum_4", out_sum, 4);
    out_ready = 1;
    tick();
    chk("bp_sum_8", out_sum, 8);
    chk("bp_valid_8", out_valid, 1);
    chk("bp_data_8", out_data, RND);
    chk("bp_in_ready_back", in_ready, 1);
    tick();
    chk("bp_drain", out_valid, 0);
    push(100); push(100);
    clear = 1;
    tick();
    clear = 0;
    chk("clr_no_out", out_valid, 0);
    chk("clr_ovf_kept", ovf_err, 1);
    push(16); push(16); push(16);
    chk("clr_not_yet", out_valid, 0);
    push(16);
    chk("clr_sum", out_sum, 64);
    chk("clr_data", out_data, 4);
    tick();
    out_ready = 0;
    group(1);
    group(1);
    chk("rp_pend", in_ready, 0);
    chk("rp_valid", out_valid, 1);
    #3 rst = 1;
    #1;
    chk("rr_valid", out_valid, 0);
    chk("rr_sum", out_sum, 0);
    chk("rr_data", out_data, 0);
    chk("rr_ovf", ovf_err, 0);
    chk("rr_in_ready", in_ready, 1);
    tick();
    rst = 0;
    out_ready = 1;
    group(1);
    chk("rr_g_valid", out_valid, 1);
    chk("rr_g_sum", out_sum, 4);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
